// File: rtl/output_writeback_buffer_pkg.sv
// Shared types for the output writeback buffer: lane/vector types and FSM states.
package output_writeback_buffer_pkg;

    localparam int ACT_DATA_WIDTH = 8;
    localparam int N_DIM_ARRAY    = 4;
    localparam int VEC_WIDTH      = ACT_DATA_WIDTH * N_DIM_ARRAY;

    typedef logic signed [ACT_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [N_DIM_ARRAY-1:0] vec_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RUN   = 2'd1,
        WB_DRAIN = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_e;

    // States in which the FIFO head may be written to memory.
    function automatic logic wb_is_active(input wb_state_e s);
        return (s == WB_RUN) || (s == WB_DRAIN);
    endfunction

endpackage

// File: rtl/output_writeback_buffer_vector_fifo.sv
// Small vector FIFO with wrap-bit pointers; supports push and pop in the same cycle.
module vector_fifo
    import output_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  vec_t                   i_wdata,
    output vec_t                   o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    vec_t           r_mem [DEPTH];

    // Read/write pointer update; the top bit distinguishes full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= (PTR_W+1)'(0);
            r_rd_ptr <= (PTR_W+1)'(0);
        end else if (i_clear) begin
            r_wr_ptr <= (PTR_W+1)'(0);
            r_rd_ptr <= (PTR_W+1)'(0);
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage write; contents are zeroed on reset so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= vec_t'(0);
        end else if (i_push && !i_clear) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/output_writeback_buffer.sv
// Buffers aligned activation vectors and writes them to activation memory
// with row/column address generation, a stall hint and sticky error flags.
module output_writeback_buffer
    import output_writeback_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_words_per_row,
    input  logic [CNT_WIDTH-1:0]  cfg_n_rows,
    input  vec_t                  input_word,
    input  logic                  input_enable,
    output logic                  almost_full,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [VEC_WIDTH-1:0]  mem_wdata,
    input  logic                  mem_gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic                  err_unexpected
);

    localparam int TOT_W = 2 * CNT_WIDTH;
    localparam int CNT_F = $clog2(FIFO_DEPTH) + 1;

    wb_state_e             r_state;
    wb_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [CNT_WIDTH-1:0]  r_words;
    logic [CNT_WIDTH-1:0]  r_col;
    logic [TOT_W-1:0]      r_total;
    logic [TOT_W-1:0]      r_received;
    logic [TOT_W-1:0]      r_written;
    logic                  r_err_overflow;
    logic                  r_err_unexpected;

    logic                  w_full;
    logic                  w_empty;
    logic [CNT_F-1:0]      w_count;
    vec_t                  w_head;
    logic                  w_req;
    logic                  w_in_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf;
    logic                  w_unexp;
    logic                  w_rcv_last;
    logic                  w_wr_last;
    logic                  w_col_last;

    assign w_req      = !w_empty && wb_is_active(r_state);
    assign w_in_ok    = input_enable && (r_state == WB_RUN) && (r_received < r_total);
    assign w_pop      = w_req && mem_gnt && !clear;
    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    assign w_push     = w_in_ok && (!w_full || w_pop) && !clear;
    assign w_ovf      = w_in_ok && w_full && !w_pop;
    assign w_unexp    = input_enable && !w_in_ok;
    assign w_rcv_last = (r_received + TOT_W'(1)) == r_total;
    assign w_wr_last  = (r_written + TOT_W'(1)) == r_total;
    assign w_col_last = (r_col == (r_words - CNT_WIDTH'(1)));

    vector_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (input_word),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; clear forces IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = WB_IDLE;
        end else begin
            case (r_state)
                WB_IDLE:  w_state_nxt = start ? WB_RUN : WB_IDLE;
                WB_RUN:   w_state_nxt = (w_push && w_rcv_last) ? WB_DRAIN : WB_RUN;
                WB_DRAIN: w_state_nxt = (w_pop && w_wr_last) ? WB_DONE : WB_DRAIN;
                WB_DONE:  w_state_nxt = WB_IDLE;
                default:  w_state_nxt = WB_IDLE;
            endcase
        end
    end

    // FSM status outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            WB_RUN, WB_DRAIN: busy = 1'b1;
            WB_DONE:          done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Job configuration, counters, incremental address generator and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_base       <= ADDR_WIDTH'(0);
            r_stride         <= ADDR_WIDTH'(0);
            r_words          <= CNT_WIDTH'(0);
            r_col            <= CNT_WIDTH'(0);
            r_total          <= TOT_W'(0);
            r_received       <= TOT_W'(0);
            r_written        <= TOT_W'(0);
            r_err_overflow   <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else if (clear) begin
            r_row_base       <= ADDR_WIDTH'(0);
            r_col            <= CNT_WIDTH'(0);
            r_total          <= TOT_W'(0);
            r_received       <= TOT_W'(0);
            r_written        <= TOT_W'(0);
            r_err_overflow   <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else begin
            if ((r_state == WB_IDLE) && start) begin
                r_row_base <= cfg_base_addr;
                r_stride   <= cfg_row_stride;
                r_words    <= cfg_words_per_row;
                r_total    <= TOT_W'(cfg_words_per_row) * TOT_W'(cfg_n_rows);
                r_col      <= CNT_WIDTH'(0);
                r_received <= TOT_W'(0);
                r_written  <= TOT_W'(0);
            end
            if (w_push) r_received <= r_received + TOT_W'(1);
            if (w_pop) begin
                r_written <= r_written + TOT_W'(1);
                if (w_col_last) begin
                    r_col      <= CNT_WIDTH'(0);
                    r_row_base <= r_row_base + r_stride;
                end else begin
                    r_col <= r_col + CNT_WIDTH'(1);
                end
            end
            if (w_ovf)   r_err_overflow   <= 1'b1;
            if (w_unexp) r_err_unexpected <= 1'b1;
        end
    end

    assign almost_full    = (w_count >= CNT_F'(FIFO_DEPTH - 1));
    assign mem_req        = w_req;
    assign mem_addr       = r_row_base + ADDR_WIDTH'(r_col);
    assign mem_wdata      = w_head;
    assign err_overflow   = r_err_overflow;
    assign err_unexpected = r_err_unexpected;

endmodule

// File: tb/tb_output_writeback_buffer.sv
// Scoreboard bench for output_writeback_buffer: expected writes are queued
// when vectors are driven and compared when the DUT issues granted writes.
module tb_output_writeback_buffer;
    import output_writeback_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        clear;
    logic [15:0] cfg_base_addr;
    logic [15:0] cfg_row_stride;
    logic [9:0]  cfg_words_per_row;
    logic [9:0]  cfg_n_rows;
    vec_t        input_word;
    logic        input_enable;
    logic        almost_full;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [VEC_WIDTH-1:0] mem_wdata;
    logic        mem_gnt;
    logic        busy;
    logic        done;
    logic        err_overflow;
    logic        err_unexpected;

    typedef struct {
        logic [15:0] addr;
        vec_t        data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    int   n_done   = 0;
    int   j_base, j_stride, j_words, push_idx;
    logic prev_stall = 1'b0;
    logic [15:0] prev_addr;
    logic [VEC_WIDTH-1:0] prev_data;

    output_writeback_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .clear             (clear),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_row_stride    (cfg_row_stride),
        .cfg_words_per_row (cfg_words_per_row),
        .cfg_n_rows        (cfg_n_rows),
        .input_word        (input_word),
        .input_enable      (input_enable),
        .almost_full       (almost_full),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_gnt           (mem_gnt),
        .busy              (busy),
        .done              (done),
        .err_overflow      (err_overflow),
        .err_unexpected    (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < N_DIM_ARRAY; l++) v[l] = lane_t'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic start_job(input int base, input int stride, input int words, input int rows);
        cfg_base_addr     = 16'(base);
        cfg_row_stride    = 16'(stride);
        cfg_words_per_row = 10'(words);
        cfg_n_rows        = 10'(rows);
        j_base = base; j_stride = stride; j_words = words; push_idx = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic push_vec(input bit accept);
        vec_t v;
        exp_t e;
        v = rand_vec();
        input_word   = v;
        input_enable = 1'b1;
        if (accept) begin
            e.addr = 16'(j_base + (push_idx / j_words) * j_stride + (push_idx % j_words));
            e.data = v;
            sb_q.push_back(e);
            push_idx++;
        end
        cycle();
        input_enable = 1'b0;
    endtask

    task automatic do_clear();
        mem_gnt = 1'b0;
        clear   = 1'b1;
        cycle();
        clear   = 1'b0;
        sb_q.delete();
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int c = 0;
        while (busy && c < budget) begin
            if (rnd) mem_gnt = 1'($urandom_range(0, 1));
            cycle();
            c++;
        end
        chk_eq("idle_within_budget", 64'(busy), 64'(0));
        cycle();
    endtask

    // Write monitor: hold-stability on stalls and in-order scoreboard compare.
    always @(negedge clk) begin
        if (reset) begin
            if (done) n_done++;
            if (prev_stall && mem_req) begin
                chk_eq("hold_addr", 64'(mem_addr), 64'(prev_addr));
                chk_eq("hold_data", 64'(mem_wdata), 64'(prev_data));
            end
            if (mem_req && mem_gnt) begin
                chk_eq("write_expected", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk_eq("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk_eq("mem_wdata", 64'(mem_wdata), 64'(e.data));
                end
                n_writes++;
            end
            prev_stall = mem_req && !mem_gnt;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, sent;
        reset = 1'b0; start = 1'b0; clear = 1'b0; mem_gnt = 1'b0;
        input_enable = 1'b0; input_word = vec_t'(0);
        cfg_base_addr = 16'h0; cfg_row_stride = 16'h0;
        cfg_words_per_row = 10'd1; cfg_n_rows = 10'd1;
        cycle(); cycle();
        chk_eq("rst_mem_req", 64'(mem_req), 64'(0));
        chk_eq("rst_busy", 64'(busy), 64'(0));
        chk_eq("rst_done", 64'(done), 64'(0));
        chk_eq("rst_almost_full", 64'(almost_full), 64'(0));
        chk_eq("rst_errs", 64'({err_overflow, err_unexpected}), 64'(0));
        chk_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk_eq("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        reset = 1'b1;
        cycle();

        // 2x3 job, grant always high, back-to-back vectors
        mem_gnt = 1'b1; w0 = n_writes; d0 = n_done;
        start_job(16'h100, 16'h10, 3, 2);
        chk_eq("t1_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 6; i++) push_vec(1'b1);
        wait_idle(50, 1'b0);
        chk_eq("t1_writes", 64'(n_writes - w0), 64'(6));
        chk_eq("t1_done_once", 64'(n_done - d0), 64'(1));
        chk_eq("t1_errs", 64'({err_overflow, err_unexpected}), 64'(0));
        chk_eq("t1_sb_empty", 64'(sb_q.size()), 64'(0));

        // Vector in IDLE, then a 7th vector on a 2x3 job
        push_vec(1'b0);
        chk_eq("t4_unexp_idle", 64'(err_unexpected), 64'(1));
        w0 = n_writes;
        start_job(16'h100, 16'h10, 3, 2);
        for (int i = 0; i < 6; i++) push_vec(1'b1);
        push_vec(1'b0);
        wait_idle(50, 1'b0);
        chk_eq("t4_writes", 64'(n_writes - w0), 64'(6));
        chk_eq("t4_unexp", 64'(err_unexpected), 64'(1));
        chk_eq("t4_no_ovf", 64'(err_overflow), 64'(0));
        do_clear();
        chk_eq("t4_clear_errs", 64'({err_overflow, err_unexpected}), 64'(0));

        // 1x8 job with grant low: FIFO fills, extra vectors overflow
        mem_gnt = 1'b0; d0 = n_done; w0 = n_writes;
        start_job(16'h200, 16'h0, 8, 1);
        for (int i = 0; i < 8; i++) begin
            push_vec(i < 4);
            chk_eq($sformatf("t2_af_%0d", i), 64'(almost_full), 64'((i + 1) >= 3));
        end
        cycle(); cycle();
        chk_eq("t2_ovf", 64'(err_overflow), 64'(1));
        chk_eq("t2_no_writes_stalled", 64'(n_writes - w0), 64'(0));
        mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk_eq("t2_stored_writes", 64'(n_writes - w0), 64'(4));
        chk_eq("t2_still_busy", 64'(busy), 64'(1));
        chk_eq("t2_no_done", 64'(n_done - d0), 64'(0));
        chk_eq("t2_req_low", 64'(mem_req), 64'(0));
        do_clear();

        // Full FIFO with a pop in the same cycle as a push
        d0 = n_done; w0 = n_writes;
        start_job(16'h300, 16'h0, 8, 1);
        for (int i = 0; i < 4; i++) push_vec(1'b1);
        chk_eq("t3_full_af", 64'(almost_full), 64'(1));
        mem_gnt = 1'b1;
        push_vec(1'b1);
        mem_gnt = 1'b0;
        chk_eq("t3_af_kept", 64'(almost_full), 64'(1));
        chk_eq("t3_no_ovf", 64'(err_overflow), 64'(0));
        chk_eq("t3_req", 64'(mem_req), 64'(1));
        mem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) push_vec(1'b1);
        wait_idle(50, 1'b0);
        chk_eq("t3_writes", 64'(n_writes - w0), 64'(8));
        chk_eq("t3_done", 64'(n_done - d0), 64'(1));
        chk_eq("t3_no_ovf_end", 64'(err_overflow), 64'(0));

        // 4x4 job with random grant stalls, producer honours almost_full
        d0 = n_done; w0 = n_writes; sent = 0;
        start_job(16'h400, 16'h20, 4, 4);
        for (int c = 0; c < 600 && sent < 16; c++) begin
            mem_gnt = 1'($urandom_range(0, 1));
            if (!almost_full) begin
                push_vec(1'b1);
                sent++;
            end else begin
                cycle();
            end
        end
        chk_eq("t5_all_sent", 64'(sent), 64'(16));
        wait_idle(400, 1'b1);
        chk_eq("t5_writes", 64'(n_writes - w0), 64'(16));
        chk_eq("t5_done", 64'(n_done - d0), 64'(1));
        chk_eq("t5_sb_empty", 64'(sb_q.size()), 64'(0));
        chk_eq("t5_no_ovf", 64'(err_overflow), 64'(0));

        // clear mid-DRAIN with two vectors queued
        mem_gnt = 1'b0;
        start_job(16'h500, 16'h0, 2, 1);
        push_vec(1'b1);
        push_vec(1'b1);
        push_vec(1'b0);
        chk_eq("t6_drain_busy", 64'(busy), 64'(1));
        chk_eq("t6_drain_req", 64'(mem_req), 64'(1));
        chk_eq("t6_unexp_set", 64'(err_unexpected), 64'(1));
        do_clear();
        chk_eq("t6_idle", 64'(busy), 64'(0));
        chk_eq("t6_req_low", 64'(mem_req), 64'(0));
        chk_eq("t6_errs_clr", 64'({err_overflow, err_unexpected}), 64'(0));
        d0 = n_done; w0 = n_writes;
        mem_gnt = 1'b1;
        start_job(16'h600, 16'h0, 1, 1);
        push_vec(1'b1);
        wait_idle(20, 1'b0);
        chk_eq("t6_1x1_write", 64'(n_writes - w0), 64'(1));
        chk_eq("t6_1x1_done", 64'(n_done - d0), 64'(1));
        chk_eq("t6_1x1_errs", 64'({err_overflow, err_unexpected}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
